// File: rtl/matvec_ctrl_part1.sv
// Load/compute/present sequencer for the 3x3 matrix-vector datapath.
// Optional MATVEC_KEEP_W_EN: keep_w reuses the stored W for the next frame.
module matvec_ctrl_part1 #(
  parameter int N    = 3,
  parameter int AX_W = $clog2(N),
  parameter int AW_W = $clog2(N*N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            out_ready,
`ifdef MATVEC_KEEP_W_EN
  input  logic            keep_w,
`endif
  output logic            out_valid,
  output logic [AX_W-1:0] out_row,
  output logic [AX_W-1:0] addr_x,
  output logic            wr_en_x,
  output logic [AW_W-1:0] addr_w,
  output logic            wr_en_w,
  output logic            clear_acc,
  output logic            en_acc,
  output logic            frame_done,
  output logic            busy
);

  typedef enum logic [2:0] {
    LOAD_W, LOAD_X, CLR, MAC, HOLD
  } state_t;

  localparam logic [AW_W-1:0] WLAST = AW_W'(N*N-1);
  localparam logic [AX_W-1:0] LAST  = AX_W'(N-1);
  localparam logic [AW_W-1:0] NW    = AW_W'(N);

  state_t state, state_nx;

  logic [AW_W-1:0] wcnt;
  logic [AX_W-1:0] xcnt;
  logic [AX_W-1:0] k;
  logic [AX_W-1:0] row;
  logic [AW_W-1:0] mac_addr;
  logic            acc_w;
  logic            acc_x;
  logic            hs;
  logic            last_row;
  logic            reuse_w;

`ifdef MATVEC_KEEP_W_EN
  assign reuse_w = keep_w;
`else
  assign reuse_w = 1'b0;
`endif

  assign acc_w    = rst && (state == LOAD_W) && in_valid;
  assign acc_x    = rst && (state == LOAD_X) && in_valid;
  assign hs       = rst && (state == HOLD) && out_ready;
  assign last_row = (row == LAST);
  assign mac_addr = AW_W'(row) * NW + AW_W'(k);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD_W;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD_W: if (acc_w && wcnt == WLAST) state_nx = LOAD_X;
      LOAD_X: if (acc_x && xcnt == LAST)  state_nx = CLR;
      CLR:    state_nx = MAC;
      MAC:    if (k == LAST) state_nx = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (!last_row)    state_nx = CLR;
          else if (reuse_w) state_nx = LOAD_X;
          else              state_nx = LOAD_W;
        end
      end
      default: state_nx = LOAD_W;
    endcase
  end

  // k parks at N-1 through HOLD so the read addresses stay put
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
      xcnt <= '0;
      k    <= '0;
      row  <= '0;
    end else begin
      if (acc_w)
        wcnt <= (wcnt == WLAST) ? '0 : wcnt + AW_W'(1);
      if (acc_x) begin
        xcnt <= (xcnt == LAST) ? '0 : xcnt + AX_W'(1);
        if (xcnt == LAST) begin
          row <= '0;
          k   <= '0;
        end
      end
      if (state == MAC && k != LAST)
        k <= k + AX_W'(1);
      if (hs) begin
        k   <= '0;
        row <= last_row ? '0 : row + AX_W'(1);
      end
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_row    = '0;
    addr_x     = '0;
    wr_en_x    = 1'b0;
    addr_w     = '0;
    wr_en_w    = 1'b0;
    clear_acc  = 1'b0;
    en_acc     = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    if (rst) begin
      unique case (state)
        LOAD_W: begin
          in_ready = 1'b1;
          addr_w   = wcnt;
          wr_en_w  = in_valid;
        end
        LOAD_X: begin
          in_ready = 1'b1;
          addr_x   = xcnt;
          wr_en_x  = in_valid;
        end
        CLR: begin
          clear_acc = 1'b1;
          busy      = 1'b1;
          addr_x    = k;
          addr_w    = mac_addr;
        end
        MAC: begin
          en_acc = 1'b1;
          busy   = 1'b1;
          addr_x = k;
          addr_w = mac_addr;
        end
        HOLD: begin
          out_valid  = 1'b1;
          out_row    = row;
          busy       = 1'b1;
          addr_x     = k;
          addr_w     = mac_addr;
          frame_done = out_ready && last_row;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_ctrl_part1.sv
// Scoreboard bench for matvec_ctrl_part1 driving a behavioural datapath.
// Expected row results are queued per frame and checked on each handshake.
module tb_matvec_ctrl_part1;
  localparam int N = 3;

  typedef logic signed [13:0] wvec_t [9];
  typedef logic signed [13:0] xvec_t [3];
  typedef int rvec_t [3];
  typedef struct {
    int row;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
`ifdef MATVEC_KEEP_W_EN
  logic keep_w = 1'b0;
`endif
  logic signed [13:0] din = '0;
  logic in_ready, out_valid, wr_en_x, wr_en_w;
  logic clear_acc, en_acc, frame_done, busy;
  logic [1:0] out_row, addr_x;
  logic [3:0] addr_w;

  always #5 clk = ~clk;

  matvec_ctrl_part1 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready),
`ifdef MATVEC_KEEP_W_EN
    .keep_w(keep_w),
`endif
    .out_valid(out_valid), .out_row(out_row),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_w(addr_w), .wr_en_w(wr_en_w),
    .clear_acc(clear_acc), .en_acc(en_acc),
    .frame_done(frame_done), .busy(busy)
  );

  // behavioural datapath: sync memories, saturating 28-bit accumulator
  logic signed [13:0] mw [16];
  logic signed [13:0] mx [4];
  logic signed [27:0] acc;

  function automatic logic signed [27:0] sat(input longint a, input longint p);
    longint s;
    s = a + p;
    if (s > 134217727)  s = 134217727;
    if (s < -134217728) s = -134217728;
    return 28'(s);
  endfunction

  always @(posedge clk) begin
    if (wr_en_w) mw[addr_w] <= din;
    if (wr_en_x) mx[addr_x] <= din;
    if (clear_acc)   acc <= '0;
    else if (en_acc) acc <= sat(acc, mw[addr_w] * mx[addr_x]);
  end

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int wq[$];
  int xq[$];
  int en_cnt = 0;
  int ov_cyc = 0;
  int fd_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      if (wr_en_w) wq.push_back(int'(addr_w));
      if (wr_en_x) xq.push_back(int'(addr_x));
      if (wr_en_w || wr_en_x) chk("strobe_gate", in_valid, 1);
      if (clear_acc) en_cnt = 0;
      if (en_acc) en_cnt++;
      if (frame_done) fd_cnt++;
      if (out_valid) begin
        ov_cyc++;
        chk("hold_quiet", en_acc | clear_acc, 0);
      end
      if (out_valid && out_ready) begin
        chk("en_per_row", en_cnt, N);
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_row", out_row, e.row);
          chk("result", acc, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [13:0] v);
    int n;
    in_valid = 1'b1;
    din = v;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    din = 14'sh1555;
  endtask

  task automatic load(input wvec_t w, input xvec_t x, input int gap, input bit do_w);
    wq.delete();
    xq.delete();
    if (do_w)
      for (int i = 0; i < 9; i++) begin
        if (i > 0) repeat (gap) tick();
        send(w[i]);
      end
    for (int i = 0; i < 3; i++) begin
      if (do_w || i > 0) repeat (gap) tick();
      send(x[i]);
    end
    chk("w_writes", wq.size(), do_w ? 9 : 0);
    for (int i = 0; i < wq.size(); i++) chk("addr_w_seq", wq[i], i);
    chk("x_writes", xq.size(), 3);
    for (int i = 0; i < xq.size(); i++) chk("addr_x_seq", xq[i], i);
  endtask

  task automatic run_rows(input rvec_t vals, input int bp_row, input int bp_cyc);
    int n;
    for (int r = 0; r < N; r++) begin
      n = 0;
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      chk("latency", n, N + 1);
      chk("out_row_seen", out_row, r);
      if (r == bp_row) begin
        repeat (bp_cyc) begin
          chk("bp_valid", out_valid, 1);
          chk("bp_row", out_row, r);
          chk("bp_quiet", en_acc | clear_acc, 0);
          chk("bp_result", acc, vals[r]);
          tick();
        end
        out_ready = 1'b1;
      end
      tick();
      if (r + 1 == bp_row) out_ready = 1'b0;
    end
    chk("frame_done", fd_cnt, 1);
    chk("ov_cycles", ov_cyc, N + (bp_row >= 0 ? bp_cyc : 0));
    chk("next_load", in_ready, 1);
  endtask

  task automatic run_frame(input wvec_t w, input xvec_t x, input rvec_t vals,
                           input int gap, input int bp_row, input int bp_cyc,
                           input bit do_w);
    ov_cyc = 0;
    fd_cnt = 0;
    for (int r = 0; r < N; r++) sb.push_back('{r, vals[r]});
    load(w, x, gap, do_w);
    run_rows(vals, bp_row, bp_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    in_valid = 1'b1;
    #12;
    chk("rst_outputs", {in_ready, out_valid, out_row, addr_x, wr_en_x, addr_w,
                        wr_en_w, clear_acc, en_acc, frame_done, busy}, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    run_frame('{2,0,0,0,2,0,0,0,2}, '{1,2,3}, '{2,4,6}, 0, -1, 0, 1'b1);
    run_frame('{2,0,0,0,2,0,0,0,2}, '{1,2,3}, '{2,4,6}, 0, 1, 5, 1'b1);
    run_frame('{1,2,3,4,5,6,7,8,9}, '{1,-1,2}, '{5,11,17}, 1, -1, 0, 1'b1);
    run_frame('{8191,8191,8191,8191,8191,8191,8191,8191,8191},
              '{8191,8191,8191},
              '{134217727,134217727,134217727}, 0, -1, 0, 1'b1);

    // reset during MAC of row 1
    for (int r = 0; r < N; r++) sb.push_back('{r, 2 * (r + 1)});
    load('{2,0,0,0,2,0,0,0,2}, '{1,2,3}, 0, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("pre_rst_valid", out_valid, 1);
    tick();
    tick();
    chk("in_mac", en_acc, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_outputs", {in_ready, out_valid, out_row, addr_x, wr_en_x,
                              addr_w, wr_en_w, clear_acc, en_acc, frame_done,
                              busy}, 0);
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel2_in_ready", in_ready, 1);
    chk("rel2_addr_w", addr_w, 0);
    chk("rel2_busy", busy, 0);
    run_frame('{1,0,0,0,1,0,0,0,1}, '{5,-6,7}, '{5,-6,7}, 0, -1, 0, 1'b1);

`ifdef MATVEC_KEEP_W_EN
    keep_w = 1'b1;
    run_frame('{2,0,0,0,2,0,0,0,2}, '{1,2,3}, '{2,4,6}, 0, -1, 0, 1'b1);
    keep_w = 1'b0;
    run_frame('{0,0,0,0,0,0,0,0,0}, '{4,5,6}, '{8,10,12}, 0, -1, 0, 1'b0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matvec_ctrl_part1.md
Name: matvec_ctrl_part1

Overview:
- Control sequencer sitting directly upstream of the part-1 matrix-vector datapath (3x3 W, 3-element x, 14-bit signed operands, 28-bit saturating accumulator).
- Accepts a valid/ready input word stream and generates the memory write strobes and addresses for W and x.
- Then runs N dot products, one row at a time, driving clear_acc/en_acc and read addresses.
- Presents each row result with an out_valid/out_ready handshake. The datapath's output_data is the result bus qualified by out_valid.

Parameters:
N, 3, matrix dimension (W is NxN, x is N)
AX_W, $clog2(N) (2), width of addr_x and out_row
AW_W, $clog2(N*N) (4), width of addr_w

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
in_valid  in  1  input_data word present on the datapath input bus
in_ready  out  1  controller accepts the word this cycle
out_ready  in  1  downstream consumes current row result
out_valid  out  1  datapath output_data holds the result for out_row
out_row  out  AX_W  row index of the presented result
addr_x  out  AX_W  x memory address
wr_en_x  out  1  x memory write strobe
addr_w  out  AW_W  W memory address
wr_en_w  out  1  W memory write strobe
clear_acc  out  1  synchronous accumulator clear
en_acc  out  1  accumulator enable
frame_done  out  1  one-cycle pulse when the last row is consumed
busy  out  1  high in CLR/MAC/HOLD

Behaviour:
- Accept: a word is accepted on a rising edge with in_valid & in_ready.
- Datapath assumptions:
  - Memories write on the clock edge when wr_en is high.
  - Memory reads are combinational.
  - The accumulator clears or adds on the edge.
- Write strobes: wr_en_w and wr_en_x are combinational (state & in_valid) and are forced 0 while rst=0.
- FSM state LOAD_W:
  - in_ready=1. addr_w=wcnt. wr_en_w=in_valid.
  - Each accept increments wcnt. The accept with wcnt=N*N-1 sets wcnt=0 and moves to LOAD_X.
  - Load order is row-major: W[i][j] goes to addr i*N+j.
- FSM state LOAD_X:
  - in_ready=1. addr_x=xcnt. wr_en_x=in_valid.
  - The accept with xcnt=N-1 sets xcnt=0, row=0 and moves to CLR.
- FSM state CLR: clear_acc=1 for exactly one cycle, in_ready=0, then MAC with k=0.
- FSM state MAC:
  - en_acc=1, addr_x=k, addr_w=row*N+k, for N consecutive cycles (k=0..N-1).
  - After k=N-1, move to HOLD.
- FSM state HOLD:
  - out_valid=1, out_row=row, en_acc=0, clear_acc=0.
  - Addresses hold their last value.
  - On out_ready: if row=N-1, pulse frame_done, go to LOAD_W. Otherwise row++, go to CLR.
- Latency: first out_valid is high N+1 cycles after the edge accepting the last x word (4 cycles for N=3). Each subsequent row takes N+1 cycles after the previous HOLD handshake.
- Outputs:
  - out_valid, en_acc and clear_acc are decoded from registered state only (glitch-free).
  - in_ready=0 outside LOAD_W/LOAD_X.
- Backpressure:
  - out_ready low holds HOLD indefinitely with out_valid/out_row stable and no accumulator activity.
  - out_ready high outside HOLD is ignored.
- in_valid gaps: counters stall, with no write strobes.
- Arithmetic: the controller does no arithmetic. Saturation is the datapath's responsibility. Addresses never exceed N*N-1 / N-1.
- Reset (rst=0, any state, including mid-MAC or HOLD):
  - Immediately go to LOAD_W.
  - wcnt=xcnt=k=row=0.
  - All outputs 0, including in_ready.
  - After rst release, in_ready=1 on the first cycle.
  - Memory contents are not touched. The accumulator is cleared by the next CLR before use.

Optional Feature:
Macro MATVEC_KEEP_W_EN.
- Defined:
  - Adds input port keep_w (1 bit), sampled on the final HOLD handshake.
  - keep_w=1 sends the FSM to LOAD_X instead of LOAD_W, so the stored W is reused and only N x words are loaded.
  - keep_w=0 behaves as baseline.
  - After reset, the first frame always starts in LOAD_W.
- Not defined: no keep_w port. Every frame loads W then x.

Test Plan:
- Load W=2*I (2,0,0,0,2,0,0,0,2) then x=(1,2,3), out_ready=1 -> results 2,4,6 with out_row 0,1,2; each out_valid is exactly one cycle; frame_done pulses once; first out_valid 4 cycles after the last x accept.
- Same frame with out_ready low for 5 cycles on row 1 -> out_valid stays 1, out_row=1, en_acc=0, clear_acc=0 throughout; result 4 is unchanged; then rows proceed.
- in_valid toggled 1,0,1,0 during load -> exactly 12 writes; addr_w 0..8 then addr_x 0..2 with no skips or repeats; no strobe while in_valid=0.
- W all 8191, x all 8191 -> every row presents 134217727 (saturated); controller issues exactly 3 en_acc cycles per row.
- Assert rst=0 during MAC of row 1 -> outputs drop to 0 asynchronously. After release: in_ready=1, LOAD_W at addr 0; a new frame W=I, x=(5,-6,7) yields 5,-6,7.
- With MATVEC_KEEP_W_EN: frame 1 with W=2*I, x=(1,2,3), keep_w=1; frame 2 loads only x=(4,5,6) -> results 8,10,12, and no wr_en_w during frame 2.
